// File: rtl/systolic_config_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer.
package systolic_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } tile_state_t;

  // Skew of the array: cycles for the last activation to reach the far corner.
  function automatic int drain_len(input int array_w, input int array_l);
    return array_w + array_l - 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_tile_ctrl_if.sv
// Command and buffer/array control bundle of the tile sequencer.
// Performance counter ports exist only with SYSTOLIC_PERF_CNT_EN.
interface systolic_tile_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int ARRAY_W    = 4,
  parameter int LEN_WIDTH  = 16
);
  import systolic_config_pkg::*;

  localparam int ROW_WIDTH = idx_width(ARRAY_W);

  logic                  start_i;
  logic [ADDR_WIDTH-1:0] w_base_i;
  logic [ADDR_WIDTH-1:0] a_base_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  a_stall_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  w_rd_en_o;
  logic [ADDR_WIDTH-1:0] w_rd_addr_o;
  logic [ROW_WIDTH-1:0]  w_row_o;
  logic                  a_rd_en_o;
  logic [ADDR_WIDTH-1:0] a_rd_addr_o;
  logic                  arr_en_o;
  logic                  out_valid_o;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0]           perf_cycles_o;
  logic [31:0]           perf_stalls_o;
`endif

  modport master (
    output start_i, w_base_i, a_base_i, len_i, a_stall_i,
    input  busy_o, done_o, w_rd_en_o, w_rd_addr_o, w_row_o,
    input  a_rd_en_o, a_rd_addr_o, arr_en_o, out_valid_o
`ifdef SYSTOLIC_PERF_CNT_EN
    , input perf_cycles_o, perf_stalls_o
`endif
  );

  modport slave (
    input  start_i, w_base_i, a_base_i, len_i, a_stall_i,
    output busy_o, done_o, w_rd_en_o, w_rd_addr_o, w_row_o,
    output a_rd_en_o, a_rd_addr_o, arr_en_o, out_valid_o
`ifdef SYSTOLIC_PERF_CNT_EN
    , output perf_cycles_o, perf_stalls_o
`endif
  );

endinterface

// File: rtl/systolic_valid_pipe.sv
// Enable-gated 1-bit shift line that tracks activations through the skewed array.
module systolic_valid_pipe #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  assign stage_next[0] = din;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else if (en) begin
      stage_reg <= stage_next;
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer: weight preload, activation stream, pipeline drain, done pulse.
// Define SYSTOLIC_PERF_CNT_EN to add the busy-cycle and stall counters.
module systolic_tile_ctrl
  import systolic_config_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  systolic_tile_ctrl_if.slave bus
);

  localparam int DRAIN_CYCLES = drain_len(ARRAY_W, ARRAY_L);
  localparam int ROW_WIDTH    = idx_width(ARRAY_W);
  localparam int DCNT_WIDTH   = idx_width(DRAIN_CYCLES);
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW   = ROW_WIDTH'(ARRAY_W - 1);
  localparam logic [DCNT_WIDTH-1:0] LAST_DRAIN = DCNT_WIDTH'(DRAIN_CYCLES - 1);

  tile_state_t           state_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  w_rd_en_reg;
  logic                  stream_reg;
  logic                  drain_reg;
  logic [ADDR_WIDTH-1:0] w_addr_reg;
  logic [ADDR_WIDTH-1:0] a_addr_reg;
  logic [ADDR_WIDTH-1:0] a_base_reg;
  logic [ROW_WIDTH-1:0]  row_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  cnt_reg;
  logic [DCNT_WIDTH-1:0] drain_cnt_reg;
  logic                  a_fire;
  logic                  arr_en;

  // Stall gates the strobes combinationally so a stalled beat never reads.
  assign a_fire = stream_reg & ~bus.a_stall_i;
  assign arr_en = a_fire | drain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      w_rd_en_reg   <= 1'b0;
      stream_reg    <= 1'b0;
      drain_reg     <= 1'b0;
      w_addr_reg    <= '0;
      a_addr_reg    <= '0;
      a_base_reg    <= '0;
      row_reg       <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      drain_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            a_base_reg <= bus.a_base_i;
            len_reg    <= bus.len_i;
            busy_reg   <= 1'b1;
            if (bus.len_i == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= LOAD_W;
              w_rd_en_reg <= 1'b1;
              w_addr_reg  <= bus.w_base_i;
              row_reg     <= '0;
            end
          end
        end
        LOAD_W: begin
          if (row_reg == LAST_ROW) begin
            state_reg   <= STREAM;
            w_rd_en_reg <= 1'b0;
            w_addr_reg  <= '0;
            row_reg     <= '0;
            stream_reg  <= 1'b1;
            a_addr_reg  <= a_base_reg;
            cnt_reg     <= '0;
          end else begin
            row_reg    <= row_reg + ROW_WIDTH'(1);
            w_addr_reg <= w_addr_reg + ADDR_WIDTH'(1);
          end
        end
        STREAM: begin
          if (!bus.a_stall_i) begin
            if (cnt_reg == len_reg - LEN_WIDTH'(1)) begin
              state_reg     <= DRAIN;
              stream_reg    <= 1'b0;
              a_addr_reg    <= '0;
              drain_reg     <= 1'b1;
              drain_cnt_reg <= '0;
            end else begin
              cnt_reg    <= cnt_reg + LEN_WIDTH'(1);
              a_addr_reg <= a_addr_reg + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == LAST_DRAIN) begin
            state_reg <= DONE;
            drain_reg <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DCNT_WIDTH'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  systolic_valid_pipe #(
    .DEPTH(DRAIN_CYCLES)
  ) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .en  (arr_en),
    .din (a_fire),
    .dout(bus.out_valid_o)
  );

  assign bus.busy_o      = busy_reg;
  assign bus.done_o      = done_reg;
  assign bus.w_rd_en_o   = w_rd_en_reg;
  assign bus.w_rd_addr_o = w_addr_reg;
  assign bus.w_row_o     = row_reg;
  assign bus.a_rd_en_o   = a_fire;
  assign bus.a_rd_addr_o = a_addr_reg;
  assign bus.arr_en_o    = arr_en;

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] perf_cycles_reg;
  logic [31:0] perf_stalls_reg;

  // Saturating counters; cleared when a command is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_reg <= '0;
      perf_stalls_reg <= '0;
    end else if (state_reg == IDLE && bus.start_i) begin
      perf_cycles_reg <= '0;
      perf_stalls_reg <= '0;
    end else begin
      if (busy_reg && perf_cycles_reg != '1) begin
        perf_cycles_reg <= perf_cycles_reg + 32'd1;
      end
      if (stream_reg && bus.a_stall_i && perf_stalls_reg != '1) begin
        perf_stalls_reg <= perf_stalls_reg + 32'd1;
      end
    end
  end

  assign bus.perf_cycles_o = perf_cycles_reg;
  assign bus.perf_stalls_o = perf_stalls_reg;
`endif

endmodule
